// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single/double-word ops, multi-cycle shifts, registered result/flags.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier for op 18.
module seq_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] ha_i,
    input  logic [WIDTH-1:0] la_i,
    input  logic [WIDTH-1:0] hb_i,
    input  logic [WIDTH-1:0] lb_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] hc_o,
    output logic [WIDTH-1:0] lc_o,
    output logic             zr_o,
    output logic             ng_o,
    output logic             carry_o,
    output logic             illegal_o
);

    localparam int unsigned DW   = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(DW);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [1:0] KindShr = 2'd0;
    localparam logic [1:0] KindShl = 2'd1;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [1:0] KindMul = 2'd2;
`endif

    state_e            state_q, state_d;
    logic [1:0]        kind_q, kind_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]     work_q, work_d;
    logic [WIDTH-1:0]  hc_q, hc_d, lc_q, lc_d;
    logic              zr_q, zr_d, ng_q, ng_d, carry_q, carry_d, illegal_q, illegal_d;
`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH:0]    msum;
`endif

    logic              dbl;
    logic [DW:0]       ax, bx, ar;
    logic              ar_c;
    logic [CntW-1:0]   k;
    logic [DW-1:0]     step;
    logic              step_c;
    logic              ld, ld_c, ld_narrow, ld_ill;
    logic [DW-1:0]     ld_res;

    assign in_ready_o  = (state_q == StIdle) && !rst_i;
    assign out_valid_o = (state_q == StDone);
    assign hc_o        = hc_q;
    assign lc_o        = lc_q;
    assign zr_o        = zr_q;
    assign ng_o        = ng_q;
    assign carry_o     = carry_q;
    assign illegal_o   = illegal_q;

    // Single-cycle datapath: operands zero-extended one bit past the active width so the
    // carry/borrow of every arithmetic op lands in bit WIDTH (narrow) or bit DW (wide).
    always_comb begin
        dbl = op_i[3];
        ax  = dbl ? {1'b0, ha_i, la_i} : {{(WIDTH + 1){1'b0}}, la_i};
        bx  = dbl ? {1'b0, hb_i, lb_i} : {{(WIDTH + 1){1'b0}}, lb_i};
        k   = la_i[CntW-1:0];
        unique case (op_i[2:0])
            3'd0:    ar = ax + bx;
            3'd1:    ar = ax - bx;
            3'd2:    ar = ax & bx;
            3'd3:    ar = ax | bx;
            3'd4:    ar = bx >> 1;
            3'd5:    ar = bx << 1;
            3'd6:    ar = bx - (DW + 1)'(1);
            default: ar = bx + (DW + 1)'(1);
        endcase
        if (op_i[2:0] == 3'd4) begin
            ar_c = bx[0];
        end else begin
            ar_c = dbl ? ar[DW] : ar[WIDTH];
        end
    end

    // One iteration of the active multi-cycle operation.
    always_comb begin
        step   = work_q >> 1;
        step_c = work_q[0];
`ifdef SEQ_ALU_MUL_EN
        msum = {1'b0, work_q[DW-1:WIDTH]} + {1'b0, (work_q[0] ? mcand_q : {WIDTH{1'b0}})};
`endif
        if (kind_q == KindShl) begin
            step   = work_q << 1;
            step_c = work_q[DW-1];
        end
`ifdef SEQ_ALU_MUL_EN
        else if (kind_q == KindMul) begin
            step   = {msum, work_q[WIDTH-1:1]};
            step_c = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        ld        = 1'b0;
        ld_res    = '0;
        ld_c      = 1'b0;
        ld_narrow = 1'b0;
        ld_ill    = 1'b0;
`ifdef SEQ_ALU_MUL_EN
        mcand_d   = mcand_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid_i && in_ready_o) begin
                    state_d = StDone;
                    if (op_i < 5'd16) begin
                        ld        = 1'b1;
                        ld_res    = dbl ? ar[DW-1:0] : {{WIDTH{1'b0}}, ar[WIDTH-1:0]};
                        ld_c      = ar_c;
                        ld_narrow = !dbl;
                    end else if (op_i == 5'd16 || op_i == 5'd17) begin
                        if (k == '0) begin
                            ld     = 1'b1;
                            ld_res = {hb_i, lb_i};
                        end else begin
                            state_d = StRun;
                            work_d  = {hb_i, lb_i};
                            cnt_d   = k;
                            kind_d  = op_i[0] ? KindShl : KindShr;
                        end
                    end
`ifdef SEQ_ALU_MUL_EN
                    else if (op_i == 5'd18) begin
                        state_d = StRun;
                        work_d  = {{WIDTH{1'b0}}, lb_i};
                        mcand_d = la_i;
                        cnt_d   = CntW'(WIDTH);
                        kind_d  = KindMul;
                    end
`endif
                    else begin
                        ld     = 1'b1;
                        ld_ill = 1'b1;
                    end
                end
            end
            StRun: begin
                work_d = step;
                cnt_d  = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    ld      = 1'b1;
                    ld_res  = step;
                    ld_c    = step_c;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        hc_d      = hc_q;
        lc_d      = lc_q;
        zr_d      = zr_q;
        ng_d      = ng_q;
        carry_d   = carry_q;
        illegal_d = illegal_q;
        if (ld) begin
            hc_d      = ld_res[DW-1:WIDTH];
            lc_d      = ld_res[WIDTH-1:0];
            zr_d      = (ld_res == '0);
            ng_d      = ld_narrow ? ld_res[WIDTH-1] : ld_res[DW-1];
            carry_d   = ld_c;
            illegal_d = ld_ill;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            kind_q    <= KindShr;
            cnt_q     <= '0;
            work_q    <= '0;
            hc_q      <= '0;
            lc_q      <= '0;
            zr_q      <= 1'b0;
            ng_q      <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mcand_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            hc_q      <= hc_d;
            lc_q      <= lc_d;
            zr_q      <= zr_d;
            ng_q      <= ng_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
`ifdef SEQ_ALU_MUL_EN
            mcand_q   <= mcand_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised bench for seq_alu against an arithmetic reference model (honours SEQ_ALU_MUL_EN).
module tb_seq_alu;

    localparam int unsigned W = 16;

    logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]   op;
    logic [W-1:0] ha, la, hb, lb, hc, lc;
    logic         zr, ng, carry, illegal;

    int n_checks = 0;
    int n_pass   = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .ha_i        (ha),
        .la_i        (la),
        .hb_i        (hb),
        .lb_i        (lb),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .hc_o        (hc),
        .lc_o        (lc),
        .zr_o        (zr),
        .ng_o        (ng),
        .carry_o     (carry),
        .illegal_o   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Word op on n-bit unsigned values using modular arithmetic.
    function automatic void wop(input int unsigned op3, input longint unsigned a,
                                input longint unsigned b, input int unsigned n,
                                output longint unsigned r, output logic c);
        longint unsigned p;
        p = 64'd1 << n;
        case (op3)
            0: begin r = (a + b) % p;     c = (a + b) >= p; end
            1: begin r = (a + p - b) % p; c = a < b;        end
            2: begin r = a & b;           c = 1'b0;         end
            3: begin r = a | b;           c = 1'b0;         end
            4: begin r = b / 2;           c = (b % 2) == 1; end
            5: begin r = (b * 2) % p;     c = b >= p / 2;   end
            6: begin r = (b + p - 1) % p; c = b == 0;       end
            default: begin r = (b + 1) % p; c = b == p - 1; end
        endcase
    endfunction

    function automatic void model(input logic [4:0] o, input logic [15:0] a_h, a_l, b_h, b_l,
                                  output logic [15:0] ehc, elc,
                                  output logic ezr, eng, ec, eil, output int elat);
        longint unsigned r, av, bv;
        logic c, narrow;
        int k;
        r = 0; c = 1'b0; narrow = 1'b0; eil = 1'b0; elat = 1;
        av = {a_h, a_l};
        bv = {b_h, b_l};
        k  = int'(a_l[4:0]);
        if (o < 8) begin
            wop(int'(o), longint'(a_l), longint'(b_l), 16, r, c);
            narrow = 1'b1;
        end else if (o < 16) begin
            wop(int'(o) - 8, av, bv, 32, r, c);
        end else if (o == 16) begin
            r = bv >> k;
            c = (k > 0) ? (((bv >> (k - 1)) & 1) != 0) : 1'b0;
            elat = k + 1;
        end else if (o == 17) begin
            r = (bv << k) & 64'hFFFF_FFFF;
            c = (k > 0) ? (((bv >> (32 - k)) & 1) != 0) : 1'b0;
            elat = k + 1;
        end
`ifdef SEQ_ALU_MUL_EN
        else if (o == 18) begin
            r = longint'(a_l) * longint'(b_l);
            elat = 17;
        end
`endif
        else begin
            eil = 1'b1;
        end
        ehc = r[31:16];
        elc = r[15:0];
        ezr = (r == 0);
        eng = narrow ? r[15] : r[31];
        ec  = c;
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns the same way.
    task automatic run_op(input logic [4:0] o, input logic [15:0] a_h, a_l, b_h, b_l,
                          input string tag);
        logic [15:0] ehc, elc;
        logic ezr, eng, ec, eil;
        int elat, lat;
        model(o, a_h, a_l, b_h, b_l, ehc, elc, ezr, eng, ec, eil, elat);
        op = o; ha = a_h; la = a_l; hb = b_h; lb = b_l;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 5'($urandom); ha = 16'($urandom); la = 16'($urandom);
        hb = 16'($urandom); lb = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".lat"}, lat, elat);
        check({tag, ".hc"}, hc, ehc);
        check({tag, ".lc"}, lc, elc);
        check({tag, ".zr"}, zr, ezr);
        check({tag, ".ng"}, ng, eng);
        check({tag, ".carry"}, carry, ec);
        check({tag, ".illegal"}, illegal, eil);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".idle"}, in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] ro;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; ha = '0; la = '0; hb = '0; lb = '0;
        #2 rst = 1'b1;
        #2;
        check("rst.valid", out_valid, 0);
        check("rst.ready", in_ready, 0);
        check("rst.hclc", {hc, lc}, 0);
        check("rst.flags", {zr, ng, carry, illegal}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("rel.ready", in_ready, 1);

        run_op(5'd0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0001, "add_wrap");
        run_op(5'd9, 16'h0001, 16'h0000, 16'h0000, 16'h0001, "dsub");
        run_op(5'd16, 16'h0000, 16'h0004, 16'h8000, 16'h0000, "shr4");
        run_op(5'd16, 16'h0000, 16'h0000, 16'h8000, 16'h0000, "shr0");
        run_op(5'd17, 16'h0000, 16'h001F, 16'h0000, 16'h0001, "shl31");
        run_op(5'd18, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, "mul");
        run_op(5'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0001, "sub_borrow");
        run_op(5'd14, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "ddec0");

        // Backpressure: result held, new requests ignored while DONE.
        op = 5'd7; lb = 16'hFFFF; la = '0; ha = '0; hb = '0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        op = 5'd0; la = 16'h0001; lb = 16'h0001;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp.valid", out_valid, 1);
            check("bp.ready", in_ready, 0);
        end
        check("bp.lc", lc, 16'h0000);
        check("bp.carry", carry, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.drain", in_ready, 1);

        // Reset in the middle of a long multi-cycle op.
        run_op(5'd8, 16'h1234, 16'h5678, 16'h1111, 16'h9999, "pre_rst");
`ifdef SEQ_ALU_MUL_EN
        op = 5'd18; la = 16'hFFFF; lb = 16'hFFFF;
`else
        op = 5'd16; la = 16'd20; hb = 16'hFFFF; lb = 16'hFFFF;
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mrst.hclc", {hc, lc}, 0);
        check("mrst.flags", {zr, ng, carry, illegal}, 0);
        check("mrst.valid", out_valid, 0);
        check("mrst.ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1 check("mrst.rel", in_ready, 1);
        run_op(5'd2, 16'h0000, 16'hF0F0, 16'h0000, 16'hFF00, "and_after_rst");

        for (int i = 0; i < 200; i++) begin
            ro = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(19, 31))
                                             : 5'($urandom_range(0, 18));
            run_op(ro, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
